// File: rtl/spi_pkg.sv
// Shared definitions for the burst SPI master: FSM states, command-byte layout
// and the SPI mode 3 clock/select idle levels.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } spi_state_t;

    // Command byte layout: R/W flag, multi-byte flag, then the register address
    localparam int RW_BIT = 7;
    localparam int MB_BIT = 6;

    // Mode 3: SCLK idles high, data launched on fall and captured on rise
    localparam logic CPOL    = 1'b1;
    localparam logic CPHA    = 1'b1;
    localparam logic SS_IDLE = 1'b1;

endpackage

// File: rtl/spi_tick.sv
// Half-period strobe generator: counts CLKDIV system clocks and pulses tick on
// the last one, reloading itself so strobes recur every CLKDIV clocks.
module spi_tick #(
    parameter int CLKDIV = 4
) (
    input  logic spiclk,
    input  logic spirstn,
    input  logic load,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLKDIV - 1);

    logic [7:0] cnt;

    // Down-counter restarted whenever the FSM enters a timed state
    always_ff @(posedge spiclk or negedge spirstn) begin
        if (!spirstn) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            cnt <= (cnt == 8'd0) ? RELOAD : cnt - 8'd1;
        end
    end

    assign tick = en && (cnt == 8'd0);

endmodule

// File: rtl/spi_burst.sv
// Mode 3 SPI master for register-mapped peripherals: one command byte followed
// by a burst of up to NBYTES data bytes, with a level request/ack handshake.
module spi_burst
    import spi_pkg::*;
#(
    parameter int CLKDIV = 4,
    parameter int NBYTES = 6,
    parameter int ADDRW  = 6
) (
    input  logic                         spiclk,
    input  logic                         spirstn,
    input  logic                         spirdav,
    input  logic                         spiwdav,
    output logic                         rdavspi,
    output logic                         wdavspi,
    input  logic [ADDRW-1:0]             spiaddr,
    input  logic [$clog2(NBYTES+1)-1:0]  spicnt,
    input  logic [8*NBYTES-1:0]          spiwdata,
    output logic [8*NBYTES-1:0]          spirdata,
    output logic                         spibusy,
    output logic                         spisclk,
    output logic                         spisdi,
    output logic                         spiss,
    input  logic                         spisdo
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam int BW = CW + 3;

    // Count of zero still sends one byte; oversize counts saturate at NBYTES
    function automatic logic [CW-1:0] eff_cnt(input logic [CW-1:0] c);
        if (c == '0)
            return CW'(1);
        else if (int'(c) > NBYTES)
            return CW'(NBYTES);
        else
            return c;
    endfunction

    spi_state_t          state;
    logic                rd_q;
    logic [CW-1:0]       n_q;
    logic [ADDRW-1:0]    addr_q;
    logic [8*NBYTES-1:0] wdata_q;
    logic [BW-1:0]       bitcnt;
    logic [7:0]          rxsh;
    logic                gap;

    logic                tick;
    logic                en;
    logic                accept;
    logic [CW-1:0]       idx;
    logic [7:0]          cmd;
    logic [7:0]          txbyte;
    logic                txbit;
    logic                last;
    logic                req;

    assign idx    = bitcnt[BW-1:3];
    assign en     = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign accept = (state == ST_IDLE) && !gap && (spirdav || spiwdav);
    assign last   = (idx == n_q) && (bitcnt[2:0] == 3'b111);
    assign req    = rd_q ? spirdav : spiwdav;

    spi_tick #(.CLKDIV(CLKDIV)) u_tick (
        .spiclk  (spiclk),
        .spirstn (spirstn),
        .load    (accept),
        .en      (en),
        .tick    (tick)
    );

    // Select the outgoing byte: command first, then write data or zeros on reads
    always_comb begin
        cmd = '0;
        cmd[ADDRW-1:0] = addr_q;
        cmd[MB_BIT]    = (n_q > CW'(1));
        cmd[RW_BIT]    = rd_q;
        txbyte = 8'h00;
        if (idx == '0) begin
            txbyte = cmd;
        end else if (!rd_q) begin
            for (int k = 0; k < NBYTES; k++)
                if (int'(idx) == k + 1)
                    txbyte = wdata_q[8*k +: 8];
        end
        txbit = txbyte[~bitcnt[2:0]];
    end

    // Transaction FSM with registered SPI pins, handshake and read data
    always_ff @(posedge spiclk or negedge spirstn) begin
        if (!spirstn) begin
            state    <= ST_IDLE;
            rd_q     <= 1'b0;
            n_q      <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            bitcnt   <= '0;
            rxsh     <= '0;
            gap      <= 1'b0;
            spiss    <= SS_IDLE;
            spisclk  <= CPOL;
            spisdi   <= 1'b0;
            spibusy  <= 1'b0;
            rdavspi  <= 1'b0;
            wdavspi  <= 1'b0;
            spirdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gap <= 1'b0;
                    if (accept) begin
                        rd_q    <= spirdav;
                        addr_q  <= spiaddr;
                        n_q     <= eff_cnt(spicnt);
                        wdata_q <= spiwdata;
                        bitcnt  <= '0;
                        spiss   <= ~SS_IDLE;
                        spibusy <= 1'b1;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        spisclk <= ~CPOL;
                        spisdi  <= txbit;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (spisclk) begin
                            spisclk <= 1'b0;
                            spisdi  <= txbit;
                        end else begin
                            spisclk <= 1'b1;
                            rxsh    <= {rxsh[6:0], spisdo};
                            if (rd_q && bitcnt[2:0] == 3'b111) begin
                                for (int k = 0; k < NBYTES; k++)
                                    if (int'(idx) == k + 1)
                                        spirdata[8*k +: 8] <= {rxsh[6:0], spisdo};
                            end
                            if (last)
                                state <= ST_HOLD;
                            else
                                bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        spiss   <= SS_IDLE;
                        spibusy <= 1'b0;
                        spisdi  <= 1'b0;
                        if (req) begin
                            if (rd_q)
                                rdavspi <= 1'b1;
                            else
                                wdavspi <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            // Abandoned request: skip the ack but keep SS high an extra clock
                            gap   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!req) begin
                        rdavspi <= 1'b0;
                        wdavspi <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst.sv
// Bench for spi_burst: a mode 3 slave model plus a byte-level reference of the
// expected MOSI stream, read-data register and handshake timing.
module tb_spi_burst;

    localparam int H = 4;

    logic        spiclk = 1'b0;
    logic        spirstn;
    logic        spirdav;
    logic        spiwdav;
    logic        rdavspi;
    logic        wdavspi;
    logic [5:0]  spiaddr;
    logic [2:0]  spicnt;
    logic [47:0] spiwdata;
    logic [47:0] spirdata;
    logic        spibusy;
    logic        spisclk;
    logic        spisdi;
    logic        spiss;
    logic        spisdo;

    int          checks = 0;
    int          errors = 0;
    bit          mosi_q[$];
    bit          miso_q[$];
    logic [47:0] rmodel;

    spi_burst #(.CLKDIV(H), .NBYTES(6), .ADDRW(6)) dut (
        .spiclk   (spiclk),
        .spirstn  (spirstn),
        .spirdav  (spirdav),
        .spiwdav  (spiwdav),
        .rdavspi  (rdavspi),
        .wdavspi  (wdavspi),
        .spiaddr  (spiaddr),
        .spicnt   (spicnt),
        .spiwdata (spiwdata),
        .spirdata (spirdata),
        .spibusy  (spibusy),
        .spisclk  (spisclk),
        .spisdi   (spisdi),
        .spiss    (spiss),
        .spisdo   (spisdo)
    );

    always #5 spiclk = ~spiclk;

    // Slave: captures MOSI on SCLK rise, launches the next MISO bit on SCLK fall
    always @(posedge spisclk) if (!spiss) mosi_q.push_back(spisdi);
    always @(negedge spisclk) if (!spiss && miso_q.size() > 0) spisdo = miso_q.pop_front();

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_n(input int c);
        if (c == 0) return 1;
        if (c > 6) return 6;
        return c;
    endfunction

    function automatic logic [7:0] cmd_of(input bit rd, input int n, input logic [5:0] a);
        return {rd, (n > 1), a};
    endfunction

    function automatic logic [7:0] mosi_byte(input int k);
        logic [7:0] b = 8'h00;
        if (mosi_q.size() >= 8*k + 8)
            for (int j = 0; j < 8; j++) b = {b[6:0], mosi_q[8*k + j]};
        return b;
    endfunction

    task automatic load_slave(input int n, input logic [47:0] resp);
        miso_q.delete();
        mosi_q.delete();
        for (int j = 0; j < 8; j++) miso_q.push_back(1'($urandom));
        for (int k = 0; k < n; k++)
            for (int b = 7; b >= 0; b--) miso_q.push_back(resp[8*k + b]);
    endtask

    task automatic check_stream(input bit rd, input int n, input logic [5:0] a, input logic [47:0] wd);
        chk("mosi_len", mosi_q.size(), 8 * (1 + n));
        chk("mosi_cmd", mosi_byte(0), cmd_of(rd, n, a));
        for (int k = 0; k < n; k++)
            chk("mosi_data", mosi_byte(k + 1), rd ? 8'h00 : wd[8*k +: 8]);
    endtask

    task automatic xfer(input bit rd, input logic [5:0] a, input int c,
                        input logic [47:0] wd, input logic [47:0] resp, input bit drop);
        int n;
        int e;
        bit done;
        n = eff_n(c);
        load_slave(n, resp);
        @(negedge spiclk);
        spiaddr  = a;
        spicnt   = 3'(c);
        spiwdata = wd;
        if (rd) spirdav = 1'b1; else spiwdav = 1'b1;
        @(posedge spiclk); #1;
        chk("ss_low", spiss, 0);
        chk("busy_high", spibusy, 1);
        spiaddr  = 6'($urandom);
        spicnt   = 3'($urandom);
        spiwdata = 48'({$urandom(), $urandom()});
        e = 0;
        done = 1'b0;
        while (!done && e < 2000) begin
            @(posedge spiclk); #1;
            e++;
            if (drop && e == 40) begin
                spirdav = 1'b0;
                spiwdav = 1'b0;
            end
            done = drop ? spiss : (rd ? rdavspi : wdavspi);
        end
        if (drop) chk("ss_release_edge", e, H * (17 + 16 * n));
        else      chk("ack_edge", e, H * (17 + 16 * n));
        chk("ss_end", spiss, 1);
        chk("busy_end", spibusy, 0);
        chk("sclk_end", spisclk, 1);
        check_stream(rd, n, a, wd);
        if (rd)
            for (int k = 0; k < n; k++) rmodel[8*k +: 8] = resp[8*k +: 8];
        chk("rdata", spirdata, rmodel);
        if (drop) begin
            repeat (3) begin
                @(posedge spiclk); #1;
                chk("no_ack", {rdavspi, wdavspi}, 0);
            end
        end else begin
            chk("other_ack", rd ? wdavspi : rdavspi, 0);
            @(negedge spiclk);
            spirdav = 1'b0;
            spiwdav = 1'b0;
            @(posedge spiclk); #1;
            chk("ack_clear", {rdavspi, wdavspi}, 0);
        end
        repeat (2) @(posedge spiclk);
    endtask

    initial begin
        int k;
        bit rd;
        spirstn  = 1'b0;
        spirdav  = 1'b0;
        spiwdav  = 1'b0;
        spiaddr  = '0;
        spicnt   = '0;
        spiwdata = '0;
        spisdo   = 1'b0;
        rmodel   = '0;
        repeat (3) @(posedge spiclk);
        #1;
        chk("rst_ss", spiss, 1);
        chk("rst_sclk", spisclk, 1);
        chk("rst_sdi", spisdi, 0);
        chk("rst_busy", spibusy, 0);
        chk("rst_ack", {rdavspi, wdavspi}, 0);
        chk("rst_rdata", spirdata, 0);
        @(negedge spiclk);
        spirstn = 1'b1;

        // Directed cases from the register-access scenarios
        xfer(1'b1, 6'h00, 1, 48'h0, 48'hE5, 1'b0);
        xfer(1'b1, 6'h32, 6, 48'h0, 48'h060504030201, 1'b0);
        xfer(1'b0, 6'h2D, 1, 48'h08, 48'hFFFFFFFFFFFF, 1'b0);
        xfer(1'b1, 6'h05, 0, 48'h0, 48'h5A, 1'b0);
        xfer(1'b0, 6'h3F, 7, 48'hA1B2C3D4E5F6, 48'h0, 1'b0);

        // Simultaneous read and write requests: read first, then the write
        load_slave(1, 48'hA5);
        @(negedge spiclk);
        spiaddr  = 6'h11;
        spicnt   = 3'd1;
        spiwdata = 48'h3C;
        spirdav  = 1'b1;
        spiwdav  = 1'b1;
        k = 0;
        while (!rdavspi && k < 2000) begin
            @(posedge spiclk); #1;
            k++;
        end
        chk("both_rd_ack", rdavspi, 1);
        chk("both_wr_wait", wdavspi, 0);
        check_stream(1'b1, 1, 6'h11, 48'h0);
        rmodel[7:0] = 8'hA5;
        chk("both_rdata", spirdata, rmodel);
        @(negedge spiclk);
        spirdav = 1'b0;
        mosi_q.delete();
        k = 0;
        while (spiss && k < 50) begin
            @(posedge spiclk); #1;
            k++;
        end
        chk("ss_gap_ok", (k >= 2 && k < 50), 1);
        k = 0;
        while (!wdavspi && k < 2000) begin
            @(posedge spiclk); #1;
            k++;
        end
        chk("both_wr_ack", wdavspi, 1);
        check_stream(1'b0, 1, 6'h11, 48'h3C);
        chk("both_rdata_kept", spirdata, rmodel);
        @(negedge spiclk);
        spiwdav = 1'b0;
        repeat (3) @(posedge spiclk);

        // Request abandoned mid-burst
        xfer(1'b1, 6'h0A, 1, 48'h0, 48'h77, 1'b1);

        // Asynchronous reset in the middle of a burst
        load_slave(6, 48'h112233445566);
        @(negedge spiclk);
        spiaddr = 6'h20;
        spicnt  = 3'd6;
        spirdav = 1'b1;
        k = 0;
        while (mosi_q.size() < 10 && k < 5000) begin
            @(posedge spiclk);
            k++;
        end
        #2;
        spirstn = 1'b0;
        #1;
        chk("mid_rst_ss", spiss, 1);
        chk("mid_rst_sclk", spisclk, 1);
        chk("mid_rst_busy", spibusy, 0);
        chk("mid_rst_ack", rdavspi, 0);
        chk("mid_rst_rdata", spirdata, 0);
        rmodel  = '0;
        spirdav = 1'b0;
        @(negedge spiclk);
        spirstn = 1'b1;
        xfer(1'b1, 6'h07, 3, 48'h0, 48'hCAFEBE, 1'b0);

        // Randomised bursts
        for (int i = 0; i < 8; i++) begin
            rd = 1'($urandom_range(0, 1));
            xfer(rd, 6'($urandom), $urandom_range(0, 7),
                 48'({$urandom(), $urandom()}), 48'({$urandom(), $urandom()}), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_burst.md
# spi_burst

Parametrised SPI master for register-mapped serial peripherals (accelerometer, gyro, ADC) on the Chapter 4 peripheral bus. It generalises single-byte register access to multi-byte bursts with the MB bit set, a programmable SCLK divider and packed multi-byte data ports. It keeps the request/acknowledge level handshake used by the other peripherals, so controllers drive it the same way.

## Interface
- CLKDIV, 4: system clocks per SCLK half-period, H; legal range 1..255.
- NBYTES, 6: maximum data bytes per burst; 6 covers an X/Y/Z 16-bit burst.
- ADDRW, 6: register address width; the command byte has 8-ADDRW-2 = 0 spare bits.
- Reset: one clock; reset is asynchronous and active-low.
- spiclk  in  1  system clock.
- spirstn  in  1  asynchronous active-low reset.
- spirdav  in  1  read request, level; held high until rdavspi=1.
- spiwdav  in  1  write request, level; held high until wdavspi=1.
- rdavspi  out  1  read done; high until spirdav is low.
- wdavspi  out  1  write done; high until spiwdav is low.
- spiaddr  in  ADDRW  start register address.
- spicnt  in  $clog2(NBYTES+1)  data byte count, n.
- spiwdata  in  8*NBYTES  write bytes; byte k is [8k+7:8k], byte 0 is sent first.
- spirdata  out  8*NBYTES  read bytes, same packing; unread bytes hold their old value.
- spibusy  out  1  high from transaction start until SS release.
- spisclk, spisdi, spiss  out  1  SCLK, MOSI and active-low chip select.
- spisdo  in  1  MISO.

## Operation
- SPI mode 3:
  - SCLK idles high.
  - MOSI changes on the falling edge.
  - MISO is sampled on the rising edge.
  - Transfers are MSB first.
- Command byte: bit7 = R/W (1 = read), bit6 = MB = (n>1), bits5:0 = spiaddr. It is followed by n data bytes.
- Count rules: spicnt=0 is treated as 1. spicnt>NBYTES is clamped to NBYTES. n is latched at start.
- spiaddr, spicnt and spiwdata are latched in IDLE when a request is accepted. Later changes are ignored.
- States:
  - IDLE: SS high. A request moves to SETUP.
  - SETUP: SS low for H clocks, then SHIFT.
  - SHIFT: 8(1+n) bits; each bit is SCLK low for H, then high for H. Moves to HOLD after the last rising edge.
  - HOLD: H clocks with SCLK high, then SS high and the ack is set; moves to DONE.
  - DONE: waits for the request to go low, clears the ack, returns to IDLE.
- If spirdav and spiwdav are both high in IDLE, the read wins. The write is served afterwards if it is still held.
- During the read data phase MOSI is driven 0.
- Received byte k is written into spirdata only when its 8th bit is sampled.
- Request dropped mid-transfer: the burst still completes and SS releases normally. The ack is not asserted; the block returns straight to IDLE.
- Reset, including mid-transfer:
  - spiss=1, spisclk=1, spisdi=0.
  - rdavspi=0, wdavspi=0, spibusy=0.
  - spirdata=0, state IDLE.

## Timing
- Edge 0 is the first clock edge at which the request is sampled high in IDLE. spiss and spibusy go low/high on edge 0.
- First SCLK fall is at edge H. Bit j falls at H+2jH and rises at 2H+2jH.
- Last rise is at 16(1+n)H. SS goes high, busy goes low and the ack rises at H(17+16n).
- The ack falls one clock after the request is sampled low. The next request is accepted no earlier than the following clock.
- SS-to-first-SCLK setup is H clocks; last-SCLK-to-SS hold is H clocks. Minimum SS-high time between bursts is 2 clocks.

## Structure
- Shared package/include spi_pkg holds:
  - state encodings: IDLE, SETUP, SHIFT, HOLD, DONE;
  - command bit positions: RW_BIT=7, MB_BIT=6;
  - SPI mode constants.
- Sub-module spi_tick: a CLKDIV down-counter producing a one-cycle half-period strobe. Reset and reload happen on state entry.
- All outputs are registered. One bit counter and one byte index live in the top level.

## Test plan
- Single read, CLKDIV=4, addr 0x00, spicnt=1, slave model returns 0xE5:
  - MOSI shows 0x80 then 0x00;
  - spirdata[7:0]=0xE5;
  - rdavspi rises at edge 132.
- Burst read of 6 bytes from addr 0x32, slave returns 01..06:
  - command byte 0xF2;
  - spirdata=48'h060504030201;
  - ack at edge 452.
- Write 0x08 to addr 0x2D, spicnt=1:
  - MOSI shows 0x2D, 0x08;
  - wdavspi rises; spirdata unchanged.
- spirdav and spiwdav raised on the same clock: the read completes first. The write follows after rdavspi clears and spirdav drops, with ≥2 clocks of SS high in between.
- spirstn pulsed low mid-burst at bit 10:
  - spiss=1, spisclk=1, spibusy=0 immediately;
  - rdavspi=0, spirdata=0.
  - The next request runs a full, correct burst.
- spicnt=0 and spicnt=7 with NBYTES=6: these run as 1 and 6 bytes, with MB=0 and MB=1 respectively.
